// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache controller: FSM states
// and the address-field width helpers used to split tag / index / offset.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WRITEBACK,
    ST_FILL,
    ST_DONE
  } cache_state_e;

  function automatic int offset_bits(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int addr_width, input int sets, input int line_bytes);
    return addr_width - $clog2(sets) - $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/cache_lru.sv
// Age-based LRU update for one set: the touched way becomes youngest (age 0),
// every way younger than its previous age grows one step older.
module cache_lru
  import cache_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int AGE_W = 2
) (
  input  logic [WAYS*AGE_W-1:0] ages_in,
  input  logic [AGE_W-1:0]      touch_way,
  output logic [WAYS*AGE_W-1:0] ages_out,
  output logic [AGE_W-1:0]      lru_way
);

  logic [AGE_W-1:0] old_age;
  logic [AGE_W-1:0] cur_age;

  always_comb begin
    old_age  = ages_in[int'(touch_way)*AGE_W +: AGE_W];
    ages_out = ages_in;
    lru_way  = '0;
    cur_age  = '0;
    for (int w = 0; w < WAYS; w++) begin
      cur_age = ages_in[w*AGE_W +: AGE_W];
      if (w == int'(touch_way))
        ages_out[w*AGE_W +: AGE_W] = '0;
      else if (cur_age < old_age)
        ages_out[w*AGE_W +: AGE_W] = cur_age + 1'b1;
      // Ages always form a permutation, so exactly one way holds the oldest age.
      if (cur_age == AGE_W'(WAYS - 1))
        lru_way = AGE_W'(w);
    end
  end

endmodule

// File: rtl/sa_cache_ctrl.sv
// Write-back, write-allocate set-associative cache controller with a line-wide
// memory port. Define CACHE_STATS_EN to add saturating hit/miss counters.
module sa_cache_ctrl
  import cache_pkg::*;
#(
  parameter int SETS       = 256,
  parameter int WAYS       = 4,
  parameter int LINE_BYTES = 64,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  output logic                    cpu_ready,
  output logic                    cpu_done,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    cpu_hit,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [LINE_BYTES*8-1:0] mem_wdata,
  input  logic                    mem_ack,
  input  logic [LINE_BYTES*8-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]             stat_hits,
  output logic [31:0]             stat_misses
`endif
);

  localparam int OFF_W  = offset_bits(LINE_BYTES);
  localparam int IDX_W  = index_bits(SETS);
  localparam int TAG_W  = tag_bits(ADDR_WIDTH, SETS, LINE_BYTES);
  localparam int AGE_W  = $clog2(WAYS);
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int BSEL_W = $clog2(DATA_WIDTH / 8);

  cache_state_e state, next_state;

  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [AGE_W-1:0]      victim_r;

  logic [LINE_W-1:0]     data_mem  [SETS][WAYS];
  logic [TAG_W-1:0]      tag_mem   [SETS][WAYS];
  logic [WAYS-1:0]       valid_mem [SETS];
  logic [WAYS-1:0]       dirty_mem [SETS];
  logic [WAYS*AGE_W-1:0] age_mem   [SETS];

  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  int                    word_idx;
  logic [WAYS-1:0]       set_valid, set_dirty, hit_vec;
  logic                  hit, has_invalid, access_done, line_wr;
  logic [AGE_W-1:0]      hit_way, inv_way, lru_way, victim_way, touch_way;
  logic [WAYS*AGE_W-1:0] set_ages, new_ages;
  logic [LINE_W-1:0]     hit_line, victim_line, upd_line;

  assign req_idx   = req_addr[OFF_W +: IDX_W];
  assign req_tag   = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign word_idx  = int'(req_addr[OFF_W-1:0]) >> BSEL_W;
  assign set_valid = valid_mem[req_idx];
  assign set_dirty = dirty_mem[req_idx];
  assign set_ages  = age_mem[req_idx];

  // Parallel tag compare; the downward scan makes the lowest invalid way win.
  always_comb begin
    hit_vec     = '0;
    hit_way     = '0;
    inv_way     = '0;
    has_invalid = 1'b0;
    for (int w = 0; w < WAYS; w++)
      hit_vec[w] = set_valid[w] && (tag_mem[req_idx][w] == req_tag);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w])
        hit_way = AGE_W'(w);
      if (!set_valid[w]) begin
        inv_way     = AGE_W'(w);
        has_invalid = 1'b1;
      end
    end
  end

  assign hit         = |hit_vec;
  assign victim_way  = has_invalid ? inv_way : lru_way;
  assign touch_way   = (state == ST_FILL) ? victim_r : hit_way;
  assign access_done = (state == ST_LOOKUP && hit) || (state == ST_FILL && mem_ack);
  assign line_wr     = (state == ST_LOOKUP && hit && req_we) || (state == ST_FILL && mem_ack);
  assign hit_line    = data_mem[req_idx][hit_way];
  assign victim_line = data_mem[req_idx][victim_r];

  always_comb begin
    upd_line = (state == ST_FILL) ? mem_rdata : hit_line;
    if (req_we)
      upd_line[word_idx*DATA_WIDTH +: DATA_WIDTH] = req_wdata;
  end

  cache_lru #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W)
  ) u_lru (
    .ages_in   (set_ages),
    .touch_way (touch_way),
    .ages_out  (new_ages),
    .lru_way   (lru_way)
  );

  always_ff @(posedge clk) begin
    if (line_wr) begin
      data_mem[req_idx][touch_way] <= upd_line;
      tag_mem[req_idx][touch_way]  <= req_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      victim_r  <= '0;
      cpu_rdata <= '0;
      cpu_hit   <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        for (int w = 0; w < WAYS; w++)
          age_mem[s][w*AGE_W +: AGE_W] <= AGE_W'(w);
      end
    end else begin
      if (cpu_req && cpu_ready) begin
        req_we    <= cpu_we;
        req_addr  <= cpu_addr;
        req_wdata <= cpu_wdata;
      end
      if (state == ST_LOOKUP && !hit)
        victim_r <= victim_way;
      if (access_done) begin
        valid_mem[req_idx][touch_way] <= 1'b1;
        if (req_we)
          dirty_mem[req_idx][touch_way] <= 1'b1;
        else if (state == ST_FILL)
          dirty_mem[req_idx][touch_way] <= 1'b0;
        age_mem[req_idx] <= new_ages;
        cpu_hit          <= (state == ST_LOOKUP);
        cpu_rdata        <= upd_line[word_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    next_state = state;
    cpu_ready  = 1'b0;
    cpu_done   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      ST_IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req)
          next_state = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (hit)
          next_state = ST_DONE;
        else if (set_valid[victim_way] && set_dirty[victim_way])
          next_state = ST_WRITEBACK;
        else
          next_state = ST_FILL;
      end
      ST_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_mem[req_idx][victim_r], req_idx, {OFF_W{1'b0}}};
        mem_wdata = victim_line;
        if (mem_ack)
          next_state = ST_FILL;
      end
      ST_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, {OFF_W{1'b0}}};
        if (mem_ack)
          next_state = ST_DONE;
      end
      ST_DONE: begin
        cpu_done   = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

`ifdef CACHE_STATS_EN
  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (cpu_done) begin
      if (cpu_hit) begin
        if (stat_hits != '1)
          stat_hits <= stat_hits + 32'd1;
      end else begin
        if (stat_misses != '1)
          stat_misses <= stat_misses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sa_cache_ctrl.sv
// Bench for sa_cache_ctrl: directed vector table, reset-abort sequence and
// random accesses scored against a timestamp-LRU cache model.
module tb_sa_cache_ctrl;

  localparam int SETS = 256;
  localparam int WAYS = 4;
  localparam int LB   = 64;
  localparam int LW   = LB * 8;
  localparam int WPL  = LB / 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [31:0]   cpu_addr, cpu_wdata;
  logic          cpu_ready, cpu_done, cpu_hit;
  logic [31:0]   cpu_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [31:0]   mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0]   stat_hits, stat_misses;
`endif

  int passed = 0;
  int total  = 0;
  int n_hits = 0;
  int n_misses = 0;
  bit hold_ack = 1'b0;

  always #5 clk = ~clk;

  sa_cache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .cpu_hit   (cpu_hit),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef CACHE_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  task automatic check_output(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Backing memory: untouched lines read back as an address-derived pattern.
  logic [LW-1:0] mem [int unsigned];

  function automatic logic [LW-1:0] pattern(input logic [31:0] la);
    logic [LW-1:0] l;
    l = '0;
    for (int i = 0; i < WPL; i++) l[i*32 +: 32] = (la + 32'(i * 4)) ^ 32'h5A5A_0000;
    return l;
  endfunction

  function automatic logic [LW-1:0] mem_line(input logic [31:0] la);
    if (mem.exists(la)) return mem[la];
    return pattern(la);
  endfunction

  logic [31:0]   txn_addr_q[$];
  bit            txn_we_q[$];
  logic [LW-1:0] txn_data_q[$];

  initial begin
    int delay = 0;
    bit last_we = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        if (!last_we && !rst) check_output("mem_req_drop_after_fill", mem_req, 1'b0);
      end else if (mem_req && !rst && !hold_ack) begin
        if (delay > 0) delay--;
        else begin
          txn_addr_q.push_back(mem_addr);
          txn_we_q.push_back(mem_we);
          txn_data_q.push_back(mem_wdata);
          last_we = mem_we;
          if (!mem_we) mem_rdata = mem_line(mem_addr);
          mem_ack = 1'b1;
          delay = $urandom_range(0, 3);
        end
      end
    end
  end

  // Reference model: per-way last-use timestamps; LRU is the oldest stamp.
  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  logic [17:0] m_tag   [SETS][WAYS];
  logic [LW-1:0] m_line [SETS][WAYS];
  int          m_stamp [SETS][WAYS];
  int          m_time;

  typedef struct packed {
    bit            hit;
    logic [31:0]   rdata;
    bit            wb;
    logic [31:0]   wb_addr;
    logic [LW-1:0] wb_line;
  } pred_t;

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_stamp[s][w] = -w;
      end
    m_time = 1;
  endfunction

  function automatic pred_t model_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    pred_t p;
    int s = int'(addr[13:6]);
    int wi = int'(addr[5:2]);
    logic [17:0] t = addr[31:14];
    int way = -1;
    p = '0;
    for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) way = w;
    p.hit = (way >= 0);
    if (!p.hit) begin
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) way = w;
      if (way < 0) begin
        way = 0;
        for (int w = 1; w < WAYS; w++) if (m_stamp[s][w] < m_stamp[s][way]) way = w;
      end
      if (m_valid[s][way] && m_dirty[s][way]) begin
        p.wb = 1'b1;
        p.wb_addr = {m_tag[s][way], 8'(s), 6'b0};
        p.wb_line = m_line[s][way];
        mem[p.wb_addr] = m_line[s][way];
      end
      m_line[s][way] = mem_line({addr[31:6], 6'b0});
      m_valid[s][way] = 1'b1;
      m_tag[s][way] = t;
      m_dirty[s][way] = 1'b0;
    end
    if (we) begin
      m_line[s][way][wi*32 +: 32] = wdata;
      m_dirty[s][way] = 1'b1;
    end
    p.rdata = m_line[s][way][wi*32 +: 32];
    m_stamp[s][way] = m_time;
    m_time++;
    return p;
  endfunction

  task automatic apply_stimulus(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                output bit done_ok, output bit got_hit, output logic [31:0] got_rdata,
                                output int latency, output bit saw_mem);
    int guard = 0;
    txn_addr_q.delete();
    txn_we_q.delete();
    txn_data_q.delete();
    done_ok = 1'b0; got_hit = 1'b0; got_rdata = '0; latency = 0; saw_mem = 1'b0;
    @(negedge clk);
    while (!cpu_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    latency = 1;
    while (!cpu_done && latency < 200) begin
      if (mem_req) saw_mem = 1'b1;
      @(posedge clk);
      #1 latency++;
    end
    if (cpu_done) begin
      done_ok = 1'b1;
      got_hit = cpu_hit;
      got_rdata = cpu_rdata;
    end
  endtask

  task automatic access_check(input string nm, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input bit exp_hit, input bit exp_wb, input logic [31:0] exp_wb_addr,
                              input logic [LW-1:0] exp_wb_line, input logic [LW-1:0] wb_mask,
                              input bit chk_rd, input logic [31:0] exp_rd);
    bit ok, h, sm;
    logic [31:0] rd;
    int lat, ntx, fi;
    apply_stimulus(we, addr, wdata, ok, h, rd, lat, sm);
    check_output($sformatf("%s.done", nm), ok, 1'b1);
    if (!ok) return;
    if (h) n_hits++; else n_misses++;
    check_output($sformatf("%s.hit", nm), h, exp_hit);
    if (chk_rd) check_output($sformatf("%s.rdata", nm), rd, exp_rd);
    ntx = exp_hit ? 0 : (exp_wb ? 2 : 1);
    check_output($sformatf("%s.mem_txns", nm), txn_addr_q.size(), ntx);
    if (exp_hit) begin
      check_output($sformatf("%s.hit_latency", nm), lat, 2);
      check_output($sformatf("%s.no_mem_req", nm), sm, 1'b0);
    end else if (txn_addr_q.size() == ntx) begin
      if (exp_wb) begin
        check_output($sformatf("%s.wb_we", nm), txn_we_q[0], 1'b1);
        check_output($sformatf("%s.wb_addr", nm), txn_addr_q[0], exp_wb_addr);
        check_output($sformatf("%s.wb_data", nm), txn_data_q[0] & wb_mask, exp_wb_line & wb_mask);
      end
      fi = exp_wb ? 1 : 0;
      check_output($sformatf("%s.fill_we", nm), txn_we_q[fi], 1'b0);
      check_output($sformatf("%s.fill_addr", nm), txn_addr_q[fi], {addr[31:6], 6'b0});
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check_output($sformatf("%s.cpu_ready", nm), cpu_ready, 1'b1);
    check_output($sformatf("%s.cpu_done", nm), cpu_done, 1'b0);
    check_output($sformatf("%s.cpu_hit", nm), cpu_hit, 1'b0);
    check_output($sformatf("%s.cpu_rdata", nm), cpu_rdata, 32'h0);
    check_output($sformatf("%s.mem_req", nm), mem_req, 1'b0);
    check_output($sformatf("%s.mem_we", nm), mem_we, 1'b0);
    check_output($sformatf("%s.mem_addr", nm), mem_addr, 32'h0);
    check_output($sformatf("%s.mem_wdata", nm), mem_wdata, '0);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_hit;
    bit          exp_wb;
    logic [31:0] exp_wb_addr;
    logic [31:0] exp_wb_word0;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[20];

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pred_t p;
    int guard;
    vecs[0]  = '{0, 32'h0000_0100, 32'h0,         0, 0, 32'h0,   32'h0,         1, 32'h5A5A_0100};
    vecs[1]  = '{0, 32'h0000_0100, 32'h0,         1, 0, 32'h0,   32'h0,         1, 32'h5A5A_0100};
    vecs[2]  = '{1, 32'h0000_0100, 32'hDEAD_BEEF, 1, 0, 32'h0,   32'h0,         0, 32'h0};
    vecs[3]  = '{0, 32'h0000_4100, 32'h0,         0, 0, 32'h0,   32'h0,         1, 32'h5A5A_4100};
    vecs[4]  = '{0, 32'h0000_8100, 32'h0,         0, 0, 32'h0,   32'h0,         1, 32'h5A5A_8100};
    vecs[5]  = '{0, 32'h0000_C100, 32'h0,         0, 0, 32'h0,   32'h0,         1, 32'h5A5A_C100};
    vecs[6]  = '{0, 32'h0001_0100, 32'h0,         0, 1, 32'h100, 32'hDEAD_BEEF, 1, 32'h5A5B_0100};
    vecs[7]  = '{0, 32'h0000_0100, 32'h0,         0, 0, 32'h0,   32'h0,         1, 32'hDEAD_BEEF};
    vecs[8]  = '{0, 32'h0000_4100, 32'h0,         0, 0, 32'h0,   32'h0,         1, 32'h5A5A_4100};
    vecs[9]  = '{0, 32'h0000_0200, 32'h0,         0, 0, 32'h0,   32'h0,         1, 32'h5A5A_0200};
    vecs[10] = '{0, 32'h0000_4200, 32'h0,         0, 0, 32'h0,   32'h0,         1, 32'h5A5A_4200};
    vecs[11] = '{0, 32'h0000_8200, 32'h0,         0, 0, 32'h0,   32'h0,         1, 32'h5A5A_8200};
    vecs[12] = '{0, 32'h0000_C200, 32'h0,         0, 0, 32'h0,   32'h0,         1, 32'h5A5A_C200};
    vecs[13] = '{0, 32'h0001_0200, 32'h0,         0, 0, 32'h0,   32'h0,         1, 32'h5A5B_0200};
    vecs[14] = '{0, 32'h0000_4200, 32'h0,         1, 0, 32'h0,   32'h0,         1, 32'h5A5A_4200};
    vecs[15] = '{0, 32'h0000_0200, 32'h0,         0, 0, 32'h0,   32'h0,         1, 32'h5A5A_0200};
    vecs[16] = '{1, 32'h0000_0304, 32'h1234_5678, 0, 0, 32'h0,   32'h0,         0, 32'h0};
    vecs[17] = '{0, 32'h0000_0304, 32'h0,         1, 0, 32'h0,   32'h0,         1, 32'h1234_5678};
    vecs[18] = '{0, 32'h0000_0300, 32'h0,         1, 0, 32'h0,   32'h0,         1, 32'h5A5A_0300};
    vecs[19] = '{0, 32'h0000_0308, 32'h0,         1, 0, 32'h0,   32'h0,         1, 32'h5A5A_0308};

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("por");

    for (int i = 0; i < 20; i++) begin
      p = model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      access_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_hit, vecs[i].exp_wb, vecs[i].exp_wb_addr,
                   LW'(vecs[i].exp_wb_word0), LW'(32'hFFFF_FFFF), vecs[i].chk_rd, vecs[i].exp_rd);
    end

    // Reset while a fill is waiting on the memory: no completion, lines invalidated.
    hold_ack = 1'b1;
    @(negedge clk);
    guard = 0;
    while (!cpu_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1000;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    guard = 0;
    while (!mem_req && guard < 20) begin
      @(posedge clk);
      #1 guard++;
    end
    check_output("abort.fill_req", mem_req, 1'b1);
    @(negedge clk);
    check_output("abort.fill_addr", mem_addr, 32'h0000_1000);
    check_output("abort.fill_we", mem_we, 1'b0);
    rst = 1'b1;
    #1 check_output("abort.mem_req_async", mem_req, 1'b0);
    @(posedge clk);
    #1 check_output("abort.mem_req_edge", mem_req, 1'b0);
    check_output("abort.no_done", cpu_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    hold_ack = 1'b0;
    model_reset();
    n_hits = 0;
    n_misses = 0;
    @(negedge clk);
    check_reset_outputs("abort_rst");
    p = model_access(1'b0, 32'h0000_1000, 32'h0);
    access_check("abort.reread", 1'b0, 32'h0000_1000, 32'h0, 1'b0, 1'b0, 32'h0, '0, '1, 1'b1, 32'h5A5A_1000);
    p = model_access(1'b0, 32'h0000_0100, 32'h0);
    access_check("abort.old_line", 1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 32'h0, '0, '1, 1'b1, 32'hDEAD_BEEF);

    for (int i = 0; i < 150; i++) begin
      bit we;
      logic [31:0] addr, wdata;
      we = 1'(($urandom & 3) == 0);
      addr = {14'(0), 4'($urandom_range(0, 5)), 8'($urandom_range(1, 2)), 4'($urandom_range(0, 15)), 2'b00};
      wdata = $urandom;
      p = model_access(we, addr, wdata);
      access_check($sformatf("rnd%0d", i), we, addr, wdata, p.hit, p.wb, p.wb_addr, p.wb_line, '1, !we, p.rdata);
    end

`ifdef CACHE_STATS_EN
    @(negedge clk);
    check_output("stat_hits", stat_hits, 32'(n_hits));
    check_output("stat_misses", stat_misses, 32'(n_misses));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sa_cache_ctrl.md
SA_CACHE_CTRL -- requirements
Module: sa_cache_ctrl

Interface
REQ-001 SHALL have parameter SETS, default 256, number of sets (power of 2).
REQ-002 SHALL have parameter WAYS, default 4, associativity (power of 2, 2..16).
REQ-003 SHALL have parameter LINE_BYTES, default 64, line size (power of 2, ≥ DATA_WIDTH/8).
REQ-004 SHALL have parameter DATA_WIDTH, default 32, CPU word width.
REQ-005 SHALL have parameter ADDR_WIDTH, default 32, byte address width; TAG = ADDR_WIDTH − log2(SETS) − log2(LINE_BYTES).
REQ-006 SHALL have port clk, input, 1, sole clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port cpu_req, input, 1, CPU request valid.
REQ-009 SHALL have port cpu_we, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have port cpu_addr, input, ADDR_WIDTH, word-aligned byte address.
REQ-011 SHALL have port cpu_wdata, input, DATA_WIDTH, write word.
REQ-012 SHALL have port cpu_ready, output, 1, controller can accept a request.
REQ-013 SHALL have port cpu_done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port cpu_rdata, output, DATA_WIDTH, read word, valid with cpu_done on reads.
REQ-015 SHALL have port cpu_hit, output, 1, completed access hit, valid with cpu_done.
REQ-016 SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, ADDR_WIDTH, line-aligned), mem_wdata (output, LINE_BYTES*8), mem_ack (input, 1), mem_rdata (input, LINE_BYTES*8): line-wide backing-memory port.

Function
REQ-017 SHALL accept a request when cpu_req && cpu_ready, registering we/addr/wdata; cpu_ready SHALL be high only in IDLE.
REQ-018 SHALL implement FSM IDLE→LOOKUP; LOOKUP→DONE on hit; LOOKUP→WRITEBACK on miss with valid dirty victim; LOOKUP→FILL on miss otherwise; WRITEBACK→FILL on mem_ack; FILL→DONE on mem_ack; DONE→IDLE.
REQ-019 SHALL compare tag against all WAYS in parallel in LOOKUP; hit = valid && tag match; at most one way matches.
REQ-020 SHALL assert cpu_done in DONE, giving hit latency of exactly 2 cycles after acceptance.
REQ-021 On read hit SHALL drive cpu_rdata with the selected word of the hitting way; on write hit SHALL update that word and set dirty.
REQ-022 On miss SHALL choose victim as the first invalid way (lowest index), else the LRU way.
REQ-023 In WRITEBACK SHALL hold mem_req=1, mem_we=1, mem_addr={victim tag,index,0}, mem_wdata=victim line until mem_ack.
REQ-024 In FILL SHALL hold mem_req=1, mem_we=0, mem_addr={req tag,index,0} until mem_ack, then install line valid, clean, merging cpu_wdata and setting dirty if the request was a write.
REQ-025 SHALL keep per-set per-way log2(WAYS)-bit age counters; on every completed access the touched way becomes age 0 and ways younger than its old age increment by 1; LRU = way with age WAYS−1.
REQ-026 SHALL ignore mem_ack outside WRITEBACK/FILL; mem_req SHALL deassert the cycle after mem_ack is sampled.
REQ-027 cpu_hit SHALL be 1 for hits, 0 for completions via FILL.

Reset
REQ-028 On rst SHALL go to IDLE, clear all valid and dirty bits, set ages of each set to way index, drive cpu_done=0, cpu_hit=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_ready=1 after release.
REQ-029 Reset mid-WRITEBACK/FILL SHALL abort the transfer immediately with no completion pulse; line data arrays need not be cleared.

Configuration
REQ-030 With CACHE_STATS_EN defined SHALL add outputs stat_hits, stat_misses (32-bit, saturating, incremented on each cpu_done per cpu_hit, cleared by rst); without it these ports and counters SHALL not exist.

Structure
REQ-031 Package cache_pkg SHALL hold the FSM state enum and width-derivation functions (tag/index/offset widths).
REQ-032 Age update SHALL live in sub-module cache_lru (per-set ages in, touched way in, ages out and LRU way out).

Verification
REQ-033 Reset, read 0x0000_0100 → FILL, mem_addr=0x0000_0100, mem_we=0, cpu_done with cpu_hit=0, rdata = filled word.
REQ-034 Repeat read 0x0000_0100 → cpu_done exactly 2 cycles after acceptance, cpu_hit=1, no mem_req.
REQ-035 Write 0xDEADBEEF to 0x100 (hit), then fill WAYS further lines into index 4 → LRU eviction emits WRITEBACK to 0x100 with word = 0xDEADBEEF before FILL.
REQ-036 Five distinct tags into one set (WAYS=4) with reads → first four fill ways 0-3, fifth evicts way 0 (oldest), no writeback (all clean).
REQ-037 Assert rst during FILL with mem_ack held low → mem_req=0 next edge, no cpu_done, subsequent read of same address misses.
REQ-038 With CACHE_STATS_EN: 3 hits + 2 misses → stat_hits=3, stat_misses=2.
